// File: rtl/fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction fetch and IF/ID register.
// Handles redirects from ID, exception entry from CP0, stalls and fetch address errors.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_4ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        int_req,
  input  logic        npc_sel,
  input  logic        eret_d,
  input  logic [31:0] npc_in,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc8_d,
  output logic        bd_d,
  output logic        exc_d,
  output logic [4:0]  exccode_d
);

  localparam logic [4:0] ExcAdEL = 5'd4;

  logic [31:0] pc_q, pc_n;
  logic [31:0] ifid_instr_q, ifid_instr_n;
  logic [31:0] ifid_pc8_q, ifid_pc8_n;
  logic        ifid_bd_q, ifid_bd_n;
  logic        ifid_exc_q, ifid_exc_n;
  logic [4:0]  ifid_code_q, ifid_code_n;
  logic        fetch_err;

  assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

  always_comb begin
    pc_n         = pc_q;
    ifid_instr_n = ifid_instr_q;
    ifid_pc8_n   = ifid_pc8_q;
    ifid_bd_n    = ifid_bd_q;
    ifid_exc_n   = ifid_exc_q;
    ifid_code_n  = ifid_code_q;
    if (int_req) begin
      pc_n         = EXC_VEC;
      ifid_instr_n = 32'h0;
      ifid_pc8_n   = 32'h0;
      ifid_bd_n    = 1'b0;
      ifid_exc_n   = 1'b0;
      ifid_code_n  = 5'd0;
    end else if (!stall) begin
      pc_n = npc_sel ? npc_in : pc_q + 32'd4;
      if (npc_sel && eret_d) begin
        // eret has no delay slot: drop the wrong-path fetch
        ifid_instr_n = 32'h0;
        ifid_pc8_n   = 32'h0;
        ifid_bd_n    = 1'b0;
        ifid_exc_n   = 1'b0;
        ifid_code_n  = 5'd0;
      end else begin
        ifid_pc8_n   = pc_q + 32'd8;
        ifid_bd_n    = npc_sel;
        ifid_instr_n = fetch_err ? 32'h0 : instr_f;
        ifid_exc_n   = fetch_err;
        ifid_code_n  = fetch_err ? ExcAdEL : 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'h0;
      ifid_pc8_q   <= 32'h0;
      ifid_bd_q    <= 1'b0;
      ifid_exc_q   <= 1'b0;
      ifid_code_q  <= 5'd0;
    end else begin
      pc_q         <= pc_n;
      ifid_instr_q <= ifid_instr_n;
      ifid_pc8_q   <= ifid_pc8_n;
      ifid_bd_q    <= ifid_bd_n;
      ifid_exc_q   <= ifid_exc_n;
      ifid_code_q  <= ifid_code_n;
    end
  end

  assign pc_f      = pc_q;
  assign instr_d   = ifid_instr_q;
  assign pc8_d     = ifid_pc8_q;
  assign bd_d      = ifid_bd_q;
  assign exc_d     = ifid_exc_q;
  assign exccode_d = ifid_code_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver queues the expected post-edge state for each
// cycle, and a negedge monitor pops and compares it against the DUT.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, int_req, npc_sel, eret_d;
  logic [31:0] npc_in, instr_f, pc_f, instr_d, pc8_d;
  logic        bd_d, exc_d;
  logic [4:0]  exccode_d;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        bd;
    logic        exc;
    logic [4:0]  code;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .int_req   (int_req),
    .npc_sel   (npc_sel),
    .eret_d    (eret_d),
    .npc_in    (npc_in),
    .instr_f   (instr_f),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc8_d     (pc8_d),
    .bd_d      (bd_d),
    .exc_d     (exc_d),
    .exccode_d (exccode_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory stand-in: distinct, nonzero word per address
  function automatic logic [31:0] im(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign instr_f = im(pc_f);

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (pc_f !== e.pc || instr_d !== e.instr || pc8_d !== e.pc8 || bd_d !== e.bd ||
          exc_d !== e.exc || exccode_d !== e.code) begin
        bad++;
        $display("FAIL %s cyc=%0d got pc=%h instr=%h pc8=%h bd=%b exc=%b code=%0d want pc=%h instr=%h pc8=%h bd=%b exc=%b code=%0d",
                 e.name, cyc, pc_f, instr_d, pc8_d, bd_d, exc_d, exccode_d,
                 e.pc, e.instr, e.pc8, e.bd, e.exc, e.code);
      end
    end
  end

  // Apply inputs for one cycle and queue the state expected after the next edge
  task automatic step(input string name, input logic rst, input logic stl, input logic irq,
                      input logic sel, input logic er, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc8, input logic e_bd, input logic e_exc);
    exp_t e;
    reset   = rst;
    stall   = stl;
    int_req = irq;
    npc_sel = sel;
    eret_d  = er;
    npc_in  = tgt;
    e.cyc   = cyc + 1;
    e.name  = name;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.pc8   = e_pc8;
    e.bd    = e_bd;
    e.exc   = e_exc;
    e.code  = e_exc ? 5'd4 : 5'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //    name       rst  stl  irq  sel  er   npc_in        pc            instr         pc8          bd   exc
    step("reset0",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3000, 32'h0,     32'h0,     1'b0, 1'b0);
    step("reset1",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3000, 32'h0,     32'h0,     1'b0, 1'b0);
    step("seq1",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3004, im(32'h3000), 32'h3008, 1'b0, 1'b0);
    step("seq2",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3008, im(32'h3004), 32'h300c, 1'b0, 1'b0);
    step("seq3",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h300c, im(32'h3008), 32'h3010, 1'b0, 1'b0);
    step("seq4",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3010, im(32'h300c), 32'h3014, 1'b0, 1'b0);
    step("branch",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3100,  32'h3100, im(32'h3010), 32'h3018, 1'b1, 1'b0);
    step("after_br",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3104, im(32'h3100), 32'h3108, 1'b0, 1'b0);
    step("stall1",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3200,  32'h3104, im(32'h3100), 32'h3108, 1'b0, 1'b0);
    step("stall2",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3200,  32'h3104, im(32'h3100), 32'h3108, 1'b0, 1'b0);
    step("unstall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3200,  32'h3200, im(32'h3104), 32'h310c, 1'b1, 1'b0);
    step("after_st",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3204, im(32'h3200), 32'h3208, 1'b0, 1'b0);
    step("to3020",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3020,  32'h3020, im(32'h3204), 32'h320c, 1'b1, 1'b0);
    step("irq_stl", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     32'h4180, 32'h0,     32'h0,     1'b0, 1'b0);
    step("handler", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h4184, im(32'h4180), 32'h4188, 1'b0, 1'b0);
    step("eret",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3044,  32'h3044, 32'h0,     32'h0,     1'b0, 1'b0);
    step("aft_eret",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3048, im(32'h3044), 32'h304c, 1'b0, 1'b0);
    step("to3002",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3002,  32'h3002, im(32'h3048), 32'h3050, 1'b1, 1'b0);
    step("mis3002", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3006, 32'h0,     32'h300a,  1'b0, 1'b1);
    step("mis3006", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5000,  32'h5000, 32'h0,     32'h300e,  1'b1, 1'b1);
    step("hi5000",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h5004, 32'h0,     32'h5008,  1'b0, 1'b1);
    step("hi5004",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4ffc,  32'h4ffc, 32'h0,     32'h500c,  1'b1, 1'b1);
    step("ok4ffc",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h5000, im(32'h4ffc), 32'h5004, 1'b0, 1'b0);
    step("hi5000b", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2ffc,  32'h2ffc, 32'h0,     32'h5008,  1'b1, 1'b1);
    step("lo2ffc",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3000, 32'h0,     32'h3004,  1'b0, 1'b1);
    step("ok3000",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3004, im(32'h3000), 32'h3008, 1'b0, 1'b0);
    step("rst_mid", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3100,  32'h3000, 32'h0,     32'h0,     1'b0, 1'b0);
    step("post_rst",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h3004, im(32'h3000), 32'h3008, 1'b0, 1'b0);
    step("to_top",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hfffffffc, 32'hfffffffc, im(32'h3004), 32'h300c, 1'b1, 1'b0);
    step("wrap",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h0,    32'h0,     32'h4,     1'b0, 1'b1);
    step("zero_pc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h4,    32'h0,     32'h8,     1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d pending entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
